cfu_initiator: RTL and testbench
================================

CFU_INITIATOR -- requirements
Module: cfu_initiator

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL set the number of in-flight request IDs (power of two, 2..16).
REQ-002 Parameter ID_W, default 2, SHALL equal log2(MAX_OUTSTANDING).
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the watchdog limit in cycles.
REQ-004 Clock and reset SHALL be: clk is the clock; rst is the reset, asynchronous, active-high.
REQ-005 The issue ports SHALL be:
- issue_valid  in  1  pipeline offers a CFU op
- issue_ready  out  1  op accepted this cycle
- issue_cfu  in  8  target CFU select
- issue_func  in  7  function code
- issue_data0, issue_data1  in  32  operands
- issue_rd  in  5  destination tag
REQ-006 The CFU request ports SHALL be:
- cfu_req_valid  out  1
- cfu_req_ready  in  1
- cfu_req_id  out  ID_W
- cfu_req_cfu  out  8
- cfu_req_func  out  7
- cfu_req_data0, cfu_req_data1  out  32
REQ-007 The CFU response ports SHALL be:
- cfu_resp_valid  in  1
- cfu_resp_ready  out  1
- cfu_resp_id  in  ID_W
- cfu_resp_status  in  3
- cfu_resp_data  in  32
REQ-008 The writeback and error ports SHALL be:
- wb_valid  out  1
- wb_ready  in  1
- wb_rd  out  5
- wb_data  out  32
- wb_status  out  3
- err_bad_id  out  1  sticky: response for a non-outstanding ID
- err_timeout  out  1  sticky: watchdog expired
- err_clear  in  1  clears both sticky flags

Function
REQ-009 Request issue:
- The block SHALL hold a slot table of MAX_OUTSTANDING entries {busy, rd}.
- issue_ready SHALL equal (any slot free at cycle start) AND (!cfu_req_valid OR cfu_req_ready).
REQ-010 On an issue handshake the block SHALL:
- allocate the lowest-numbered free slot;
- store rd in that slot;
- drive cfu_req_* from registers in the next cycle, with cfu_req_id equal to the slot index (1-cycle latency).
REQ-011 cfu_req_valid SHALL remain high with a stable payload until cfu_req_ready is sampled high; back-to-back requests SHALL sustain 1 per cycle.
REQ-012 Response path:
- cfu_resp_ready SHALL equal wb_ready.
- wb_valid SHALL equal cfu_resp_valid (combinational pass-through).
- wb_data = cfu_resp_data; wb_status = cfu_resp_status; wb_rd = slot[cfu_resp_id].rd.
REQ-013 Responses SHALL be accepted in any order, matched by ID; the slot SHALL be freed on the resp handshake.
REQ-014 A response handshake whose slot is not busy SHALL set err_bad_id, drive wb_valid low, and still assert cfu_resp_ready so the CFU is drained.
REQ-015 Same-cycle free and allocate:
- a slot freed this cycle SHALL NOT be reallocated in the same cycle;
- a free and an allocate of different slots in one cycle SHALL both take effect.
REQ-016 Watchdog:
- it SHALL count while any slot is busy and no resp handshake occurs;
- it SHALL reset to 0 on any resp handshake or when no slot is busy.
REQ-017 When the watchdog reaches TIMEOUT_CYCLES-1 the block SHALL, in the next cycle:
- set err_timeout;
- clear all slots;
- drop cfu_req_valid;
- return the counter to 0.
REQ-018 err_clear SHALL clear both sticky flags; a same-cycle set SHALL win over clear.

Reset
REQ-019 On reset, all slots SHALL be free and the following outputs SHALL be 0: cfu_req_valid, cfu_req_id, cfu_req_cfu, cfu_req_func, cfu_req_data0, cfu_req_data1, err_bad_id, err_timeout, watchdog.
REQ-020 Reset asserted mid-transaction SHALL abandon all outstanding IDs; no writeback SHALL be produced for them after reset.
REQ-021 issue_ready SHALL be 0 while rst is high and SHALL become 1 in the first cycle after rst deasserts.

Structure
REQ-022 A shared package cfu_pkg SHALL hold:
- the widths CFU_SEL_W=8, CFU_FUNC_W=7, CFU_STATUS_W=3, XLEN=32;
- an enum of status codes (OK=0, ERR=1).
REQ-023 A sub-module cfu_id_pool SHALL implement the slot busy bits, the lowest-free priority encoder, and alloc/free.

Verification
REQ-024 Single op: issue cfu=1, func=0, data0=0x12345678, rd=7; CFU responds 3 cycles later with data 0xABCD -> cfu_req_id=0, wb_rd=7, wb_data=0xABCD.
REQ-025 Out-of-order: issue 4 ops with rd=1,2,3,4; respond with IDs 3,0,2,1 -> wb_rd sequence 4,1,3,2, and issue_ready=0 until the first response.
REQ-026 Backpressure: cfu_req_ready held low for 5 cycles -> cfu_req_valid and payload stable across all 5 cycles, and exactly one request is sent.
REQ-027 Bad ID: respond with ID 2 while no slot is busy -> err_bad_id=1, wb_valid=0, cfu_resp_ready=1.
REQ-028 Timeout: TIMEOUT_CYCLES=16, issue one op, never respond -> err_timeout=1 sixteen cycles after issue, all slots free, and the next issue gets ID 0.
REQ-029 Reset mid-flight: 2 ops outstanding, pulse rst -> all outputs 0, and the late responses raise err_bad_id.

Source files
------------

// File: rtl/cfu_pkg.sv
// rtl/cfu_pkg.sv - shared widths and status codes for the CFU initiator
package cfu_pkg;

    localparam int CFU_SEL_W    = 8;
    localparam int CFU_FUNC_W   = 7;
    localparam int CFU_STATUS_W = 3;
    localparam int XLEN         = 32;
    localparam int RD_W         = 5;

    typedef enum logic [CFU_STATUS_W-1:0] {
        CFU_OK  = 3'd0,
        CFU_ERR = 3'd1
    } cfu_status_e;

endpackage

// File: rtl/cfu_id_pool.sv
// rtl/cfu_id_pool.sv - request ID pool: busy bits, lowest-free encoder, alloc/free/clear
module cfu_id_pool #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic            free,
    input  logic [ID_W-1:0] free_id,
    input  logic            clear,
    output logic [ID_W-1:0] alloc_id,
    output logic            any_free,
    output logic            any_busy,
    output logic [N-1:0]    busy
);

    // Encoder works on the registered busy bits, so a slot freed this cycle
    // still looks busy and cannot be handed out again until the next cycle.
    always_comb begin
        alloc_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                alloc_id = ID_W'(i);
            end
        end
    end

    assign any_free = ~&busy;
    assign any_busy = |busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (clear) begin
            busy <= '0;
        end else begin
            if (free) begin
                busy[free_id] <= 1'b0;
            end
            if (alloc) begin
                busy[alloc_id] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfu_initiator.sv
// rtl/cfu_initiator.sv - issues tagged CFU requests and routes out-of-order responses to writeback
module cfu_initiator
    import cfu_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ID_W            = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [CFU_SEL_W-1:0]    issue_cfu,
    input  logic [CFU_FUNC_W-1:0]   issue_func,
    input  logic [XLEN-1:0]         issue_data0,
    input  logic [XLEN-1:0]         issue_data1,
    input  logic [RD_W-1:0]         issue_rd,

    output logic                    cfu_req_valid,
    input  logic                    cfu_req_ready,
    output logic [ID_W-1:0]         cfu_req_id,
    output logic [CFU_SEL_W-1:0]    cfu_req_cfu,
    output logic [CFU_FUNC_W-1:0]   cfu_req_func,
    output logic [XLEN-1:0]         cfu_req_data0,
    output logic [XLEN-1:0]         cfu_req_data1,

    input  logic                    cfu_resp_valid,
    output logic                    cfu_resp_ready,
    input  logic [ID_W-1:0]         cfu_resp_id,
    input  logic [CFU_STATUS_W-1:0] cfu_resp_status,
    input  logic [XLEN-1:0]         cfu_resp_data,

    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [RD_W-1:0]         wb_rd,
    output logic [XLEN-1:0]         wb_data,
    output logic [CFU_STATUS_W-1:0] wb_status,
    output logic                    err_bad_id,
    output logic                    err_timeout,
    input  logic                    err_clear
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [MAX_OUTSTANDING-1:0] busy;
    logic [ID_W-1:0]            alloc_id;
    logic                       any_free;
    logic                       any_busy;
    logic [RD_W-1:0]            slot_rd [MAX_OUTSTANDING];
    logic [WD_W-1:0]            watchdog;

    logic issue_hs;
    logic resp_hit;
    logic resp_hs;
    logic free_slot;
    logic bad_id;
    logic expire;

    cfu_id_pool #(
        .N    (MAX_OUTSTANDING),
        .ID_W (ID_W)
    ) u_pool (
        .clk      (clk),
        .rst      (rst),
        .alloc    (issue_hs),
        .free     (free_slot),
        .free_id  (cfu_resp_id),
        .clear    (expire),
        .alloc_id (alloc_id),
        .any_free (any_free),
        .any_busy (any_busy),
        .busy     (busy)
    );

    assign issue_ready = !rst && any_free && !expire && (!cfu_req_valid || cfu_req_ready);
    assign issue_hs    = issue_valid && issue_ready;

    // A response to an idle slot is always drained, even when writeback stalls.
    assign resp_hit       = busy[cfu_resp_id];
    assign cfu_resp_ready = wb_ready || (cfu_resp_valid && !resp_hit);
    assign resp_hs        = cfu_resp_valid && cfu_resp_ready;
    assign free_slot      = resp_hs && resp_hit;
    assign bad_id         = resp_hs && !resp_hit;

    assign wb_valid  = cfu_resp_valid && resp_hit;
    assign wb_rd     = slot_rd[cfu_resp_id];
    assign wb_data   = cfu_resp_data;
    assign wb_status = cfu_resp_status;

    assign expire = any_busy && !resp_hs && (watchdog == WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watchdog <= '0;
        end else if (expire || resp_hs || !any_busy) begin
            watchdog <= '0;
        end else begin
            watchdog <= watchdog + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                slot_rd[i] <= '0;
            end
        end else if (issue_hs) begin
            slot_rd[alloc_id] <= issue_rd;
        end
    end

    // Payload only moves on a new issue, so it is stable while the CFU stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfu_req_valid <= 1'b0;
            cfu_req_id    <= '0;
            cfu_req_cfu   <= '0;
            cfu_req_func  <= '0;
            cfu_req_data0 <= '0;
            cfu_req_data1 <= '0;
        end else if (expire) begin
            cfu_req_valid <= 1'b0;
        end else if (issue_hs) begin
            cfu_req_valid <= 1'b1;
            cfu_req_id    <= alloc_id;
            cfu_req_cfu   <= issue_cfu;
            cfu_req_func  <= issue_func;
            cfu_req_data0 <= issue_data0;
            cfu_req_data1 <= issue_data1;
        end else if (cfu_req_ready) begin
            cfu_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_bad_id  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_bad_id  <= (err_bad_id && !err_clear) || bad_id;
            err_timeout <= (err_timeout && !err_clear) || expire;
        end
    end

endmodule

// File: tb/tb_cfu_initiator.sv
// tb/tb_cfu_initiator.sv - randomized self-checking bench for cfu_initiator
module tb_cfu_initiator;
    import cfu_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [7:0]  issue_cfu;
    logic [6:0]  issue_func;
    logic [31:0] issue_data0, issue_data1;
    logic [4:0]  issue_rd;
    logic        cfu_req_valid, cfu_req_ready;
    logic [1:0]  cfu_req_id;
    logic [7:0]  cfu_req_cfu;
    logic [6:0]  cfu_req_func;
    logic [31:0] cfu_req_data0, cfu_req_data1;
    logic        cfu_resp_valid, cfu_resp_ready;
    logic [1:0]  cfu_resp_id;
    logic [2:0]  cfu_resp_status;
    logic [31:0] cfu_resp_data;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  wb_status;
    logic        err_bad_id, err_timeout, err_clear;

    cfu_initiator #(.MAX_OUTSTANDING(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_cfu(issue_cfu),
        .issue_func(issue_func), .issue_data0(issue_data0), .issue_data1(issue_data1),
        .issue_rd(issue_rd),
        .cfu_req_valid(cfu_req_valid), .cfu_req_ready(cfu_req_ready), .cfu_req_id(cfu_req_id),
        .cfu_req_cfu(cfu_req_cfu), .cfu_req_func(cfu_req_func),
        .cfu_req_data0(cfu_req_data0), .cfu_req_data1(cfu_req_data1),
        .cfu_resp_valid(cfu_resp_valid), .cfu_resp_ready(cfu_resp_ready), .cfu_resp_id(cfu_resp_id),
        .cfu_resp_status(cfu_resp_status), .cfu_resp_data(cfu_resp_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_status(wb_status), .err_bad_id(err_bad_id), .err_timeout(err_timeout),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int req_sent = 0;

    always @(posedge clk) begin
        if (!rst && cfu_req_valid && cfu_req_ready) req_sent++;
    end

    // Reference model: which IDs are outstanding and the rd each one carries.
    bit         mbusy [N];
    logic [4:0] mrd   [N];

    function automatic int lowest_free();
        for (int i = 0; i < N; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (mbusy[i]) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mbusy[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [7:0] c, input logic [6:0] f, input logic [31:0] d0,
                            input logic [31:0] d1, input logic [4:0] rd);
        int e;
        e = lowest_free();
        issue_valid = 1'b1; issue_cfu = c; issue_func = f;
        issue_data0 = d0; issue_data1 = d1; issue_rd = rd;
        #1;
        checks++;
        if (issue_ready !== (e >= 0)) begin
            errors++; $display("FAIL issue_ready got %0b exp %0b", issue_ready, (e >= 0));
        end
        tick();
        issue_valid = 1'b0;
        if (e >= 0) begin
            mbusy[e] = 1'b1; mrd[e] = rd;
            checks++;
            if (cfu_req_valid !== 1'b1 || cfu_req_id !== IDW'(e) || cfu_req_cfu !== c ||
                cfu_req_func !== f || cfu_req_data0 !== d0 || cfu_req_data1 !== d1) begin
                errors++;
                $display("FAIL req_payload got v=%0b id=%0d cfu=%0h f=%0h d0=%h d1=%h exp id=%0d cfu=%0h f=%0h d0=%h d1=%h",
                         cfu_req_valid, cfu_req_id, cfu_req_cfu, cfu_req_func, cfu_req_data0,
                         cfu_req_data1, e, c, f, d0, d1);
            end
        end
    endtask

    task automatic do_resp(input logic [1:0] id, input logic [31:0] data, input logic [2:0] st);
        bit was_busy;
        was_busy = mbusy[id];
        cfu_resp_valid = 1'b1; cfu_resp_id = id; cfu_resp_data = data; cfu_resp_status = st;
        wb_ready = 1'b1;
        #1;
        checks++;
        if (wb_valid !== was_busy) begin
            errors++; $display("FAIL wb_valid id=%0d got %0b exp %0b", id, wb_valid, was_busy);
        end
        checks++;
        if (cfu_resp_ready !== 1'b1) begin
            errors++; $display("FAIL cfu_resp_ready got %0b exp 1", cfu_resp_ready);
        end
        if (was_busy) begin
            checks++;
            if (wb_rd !== mrd[id] || wb_data !== data || wb_status !== st) begin
                errors++;
                $display("FAIL wb_payload id=%0d got rd=%0d data=%h st=%0d exp rd=%0d data=%h st=%0d",
                         id, wb_rd, wb_data, wb_status, mrd[id], data, st);
            end
        end
        tick();
        cfu_resp_valid = 1'b0;
        mbusy[id] = 1'b0;
        if (!was_busy) begin
            checks++;
            if (err_bad_id !== 1'b1) begin
                errors++; $display("FAIL err_bad_id_set got %0b exp 1", err_bad_id);
            end
        end
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (err_bad_id !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL err_clear got bad=%0b to=%0b exp 0 0", err_bad_id, err_timeout);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) if (mbusy[i]) do_resp(IDW'(i), $urandom, 3'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 0; issue_cfu = 0; issue_func = 0; issue_data0 = 0; issue_data1 = 0; issue_rd = 0;
        cfu_req_ready = 1'b1; cfu_resp_valid = 0; cfu_resp_id = 0; cfu_resp_status = 0;
        cfu_resp_data = 0; wb_ready = 1'b1; err_clear = 0;
        model_clear();
        tick(); tick();
        checks++;
        if (issue_ready !== 1'b0 || cfu_req_valid !== 1'b0 || cfu_req_id !== 2'd0 ||
            cfu_req_data0 !== 32'd0 || err_bad_id !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ir=%0b rv=%0b id=%0d d0=%h bad=%0b to=%0b exp all 0",
                     issue_ready, cfu_req_valid, cfu_req_id, cfu_req_data0, err_bad_id, err_timeout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset got %0b exp 1", issue_ready);
        end
    endtask

    task automatic test_single();
        do_issue(8'd1, 7'd0, 32'h1234_5678, 32'h0, 5'd7);
        tick(); tick();
        do_resp(2'd0, 32'h0000_ABCD, CFU_OK);
    endtask

    task automatic test_out_of_order();
        logic [1:0] order [4];
        order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd2; order[3] = 2'd1;
        for (int k = 0; k < 4; k++) do_issue(8'($urandom), 7'($urandom), $urandom, $urandom, 5'(k + 1));
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %0b exp 0", issue_ready);
        end
        for (int k = 0; k < 4; k++) do_resp(order[k], $urandom, CFU_OK);
    endtask

    task automatic test_back_to_back();
        int e;
        logic [31:0] d;
        for (int k = 0; k < 3; k++) begin
            e = lowest_free();
            d = $urandom;
            issue_valid = 1'b1; issue_rd = 5'(20 + k); issue_data0 = d;
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready k=%0d got %0b exp 1", k, issue_ready);
            end
            tick();
            mbusy[e] = 1'b1; mrd[e] = 5'(20 + k);
            checks++;
            if (cfu_req_valid !== 1'b1 || cfu_req_id !== IDW'(e) || cfu_req_data0 !== d) begin
                errors++;
                $display("FAIL b2b_req k=%0d got v=%0b id=%0d d0=%h exp 1 %0d %h",
                         k, cfu_req_valid, cfu_req_id, cfu_req_data0, e, d);
            end
        end
        issue_valid = 1'b0;
        do_resp(2'd1, $urandom, CFU_ERR);
        drain();
    endtask

    task automatic test_backpressure();
        int snap;
        snap = req_sent;
        cfu_req_ready = 1'b0;
        do_issue(8'h5A, 7'h33, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd9);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (cfu_req_valid !== 1'b1 || cfu_req_id !== 2'd0 || cfu_req_cfu !== 8'h5A ||
                cfu_req_func !== 7'h33 || cfu_req_data0 !== 32'hDEAD_BEEF ||
                cfu_req_data1 !== 32'hCAFE_F00D || issue_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold k=%0d got v=%0b id=%0d d0=%h d1=%h ir=%0b", k,
                         cfu_req_valid, cfu_req_id, cfu_req_data0, cfu_req_data1, issue_ready);
            end
            tick();
        end
        cfu_req_ready = 1'b1;
        tick();
        checks++;
        if (cfu_req_valid !== 1'b0 || (req_sent - snap) !== 1) begin
            errors++; $display("FAIL bp_sent got v=%0b sent=%0d exp 0 1", cfu_req_valid, req_sent - snap);
        end
        drain();
    endtask

    task automatic test_bad_id();
        do_resp(2'd2, 32'h1111_2222, CFU_OK);
        clear_errors();
    endtask

    task automatic test_timeout();
        do_issue(8'd3, 7'd1, $urandom, $urandom, 5'd11);
        do_issue(8'd3, 7'd2, $urandom, $urandom, 5'd12);
        for (int k = 0; k < 14; k++) tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_early got %0b exp 0", err_timeout);
        end
        tick();
        model_clear();
        checks++;
        if (err_timeout !== 1'b1 || cfu_req_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_fire got to=%0b rv=%0b exp 1 0", err_timeout, cfu_req_valid);
        end
        do_resp(2'd1, $urandom, CFU_OK);
        clear_errors();
        do_issue(8'd4, 7'd5, $urandom, $urandom, 5'd13);
        drain();
    endtask

    task automatic test_reset_midflight();
        do_issue(8'hA1, 7'h11, 32'h0BAD_F00D, $urandom, 5'd30);
        do_issue(8'hA2, 7'h12, 32'h0123_4567, $urandom, 5'd31);
        cfu_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (cfu_req_valid !== 1'b0 || cfu_req_id !== 2'd0 || cfu_req_cfu !== 8'd0 ||
            cfu_req_func !== 7'd0 || cfu_req_data0 !== 32'd0 || cfu_req_data1 !== 32'd0 ||
            issue_ready !== 1'b0 || err_bad_id !== 1'b0 || err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL midflight_reset got rv=%0b id=%0d d0=%h ir=%0b exp all 0",
                     cfu_req_valid, cfu_req_id, cfu_req_data0, issue_ready);
        end
        tick();
        rst = 1'b0;
        cfu_req_ready = 1'b1;
        model_clear();
        do_resp(2'd0, $urandom, CFU_OK);
        do_resp(2'd1, $urandom, CFU_OK);
        clear_errors();
    endtask

    task automatic test_random();
        int live [$];
        for (int it = 0; it < 60; it++) begin
            if (busy_count() < N && (busy_count() == 0 || $urandom_range(0, 1) == 1)) begin
                do_issue(8'($urandom), 7'($urandom), $urandom, $urandom, 5'($urandom));
            end else begin
                live.delete();
                for (int i = 0; i < N; i++) if (mbusy[i]) live.push_back(i);
                do_resp(IDW'(live[$urandom_range(0, live.size() - 1)]), $urandom,
                        3'($urandom_range(0, 7)));
            end
        end
        drain();
        checks++;
        if (err_bad_id !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL random_errs got bad=%0b to=%0b exp 0 0", err_bad_id, err_timeout);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_out_of_order();
        test_back_to_back();
        test_backpressure();
        test_bad_id();
        test_timeout();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
